// File: rtl/sdr_dsp_pkg.sv
// Shared DSP helpers: round-half-up / arithmetic shift / saturate, used by
// several datapath blocks so they all clamp and flag overflow identically.
package sdr_dsp_pkg;

    // Internal working width for sat_round; wide enough for any caller's accumulator.
    localparam int MAXW = 64;

    typedef struct packed {
        logic                   ovf;
        logic signed [MAXW-1:0] y;
    } sat_t;

    // Round half up by 2**(shift-1), shift right arithmetically, then clamp to
    // a signed ow-bit range. ovf reports that the clamp was applied.
    function automatic sat_t sat_round(input logic signed [MAXW-1:0] val,
                                       input int shift,
                                       input int ow);
        logic signed [MAXW-1:0] one;
        logic signed [MAXW-1:0] r;
        logic signed [MAXW-1:0] hi;
        logic signed [MAXW-1:0] lo;
        sat_t res;
        one = 1;
        r   = val;
        if (shift > 0) begin
            r = r + (one <<< (shift - 1));
        end
        r  = r >>> shift;
        hi = (one <<< (ow - 1)) - one;
        lo = ~hi;
        res.ovf = 1'b0;
        res.y   = r;
        if (r > hi) begin
            res.ovf = 1'b1;
            res.y   = hi;
        end else if (r < lo) begin
            res.ovf = 1'b1;
            res.y   = lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/sdr_round_sat.sv
// Output stage for one component: round, shift and saturate the accumulator
// and register the result. Holds its value until the next enabled update.
module sdr_round_sat
    import sdr_dsp_pkg::*;
#(
    parameter int IW    = 29,
    parameter int OW    = 21,
    parameter int SHIFT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 en,
    input  logic signed [IW-1:0] val,
    output logic signed [OW-1:0] y,
    output logic                 ovf
);

    sat_t res;
    logic unused_hi;

    // Combinational round/saturate of the current accumulator value.
    always_comb begin
        res = sat_round(MAXW'(val), SHIFT, OW);
    end

    // After saturation the bits above OW are pure sign copies.
    assign unused_hi = ^res.y[MAXW-1:OW];

    // Capture a new result only when a dump is presented; otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y   <= '0;
            ovf <= 1'b0;
        end else if (ce && en) begin
            y   <= res.y[OW-1:0];
            ovf <= res.ovf;
        end
    end

endmodule

// File: rtl/sdr_cmult_pipe.sv
// Pipelined signed complex multiplier (optionally a*conj(b)) followed by an
// integrate-and-dump accumulator and a rounding/saturating output stage.
// Five register stages; ce freezes every register including valid and count.
module sdr_cmult_pipe
    import sdr_dsp_pkg::*;
#(
    parameter int AW    = 10,
    parameter int BW    = 10,
    parameter int OW    = 21,
    parameter int SHIFT = 0,
    parameter int ACCW  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ce,
    input  logic                   in_valid,
    input  logic signed [AW-1:0]   a_i,
    input  logic signed [AW-1:0]   a_q,
    input  logic signed [BW-1:0]   b_i,
    input  logic signed [BW-1:0]   b_q,
    input  logic                   conj_b,
    input  logic [ACCW-1:0]        acc_len,
    output logic                   out_valid,
    output logic signed [OW-1:0]   y_i,
    output logic signed [OW-1:0]   y_q,
    output logic                   ovf
);

    localparam int PRW = AW + BW;      // single partial product
    localparam int PW  = AW + BW + 1;  // sum of two products, never wraps
    localparam int SW  = PW + ACCW;    // accumulator, holds 2**ACCW-1 products

    // S1 operand registers
    logic signed [AW-1:0]   a_i_r, a_q_r;
    logic signed [BW-1:0]   b_i_r, b_q_r;
    logic                   conj1, v1;
    // S2 partial products
    logic signed [PRW-1:0]  p_ii, p_qq, p_iq, p_qi;
    logic                   conj2, v2;
    // S3 complex product
    logic signed [PW-1:0]   re, im;
    logic                   v3;
    // S4 integrate-and-dump
    logic signed [SW-1:0]   acc_re, acc_im;
    logic [ACCW-1:0]        cnt, len_l, len_sel;
    logic                   last_prod, v4;
    logic                   ovf_i, ovf_q;

    // S1: capture operands and their qualifiers together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_i_r <= '0;
            a_q_r <= '0;
            b_i_r <= '0;
            b_q_r <= '0;
            conj1 <= 1'b0;
            v1    <= 1'b0;
        end else if (ce) begin
            // NOTE: non-blocking so every stage samples its predecessor's old value.
            a_i_r <= a_i;
            a_q_r <= a_q;
            b_i_r <= b_i;
            b_q_r <= b_q;
            conj1 <= conj_b;
            v1    <= in_valid;
        end
    end

    // S2: four full-width signed products, kept as separate registers for DSP mapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_ii  <= '0;
            p_qq  <= '0;
            p_iq  <= '0;
            p_qi  <= '0;
            conj2 <= 1'b0;
            v2    <= 1'b0;
        end else if (ce) begin
            p_ii  <= PRW'(a_i_r) * PRW'(b_i_r);
            p_qq  <= PRW'(a_q_r) * PRW'(b_q_r);
            p_iq  <= PRW'(a_i_r) * PRW'(b_q_r);
            p_qi  <= PRW'(a_q_r) * PRW'(b_i_r);
            conj2 <= conj1;
            v2    <= v1;
        end
    end

    // S3: combine partial products; conj flips the sign of b_q's contribution.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            re <= '0;
            im <= '0;
            v3 <= 1'b0;
        end else if (ce) begin
            if (conj2) begin
                re <= PW'(p_ii) + PW'(p_qq);
                im <= PW'(p_qi) - PW'(p_iq);
            end else begin
                re <= PW'(p_ii) - PW'(p_qq);
                im <= PW'(p_qi) + PW'(p_iq);
            end
            v3 <= v2;
        end
    end

    // Window length comes from acc_len on the first product, from the latch after.
    always_comb begin
        // NOTE: every output gets a value on every path, so no latch is inferred.
        len_sel   = (cnt == '0) ? acc_len : len_l;
        last_prod = ({1'b0, cnt} + (ACCW + 1)'(1)) >= {1'b0, len_sel};
    end

    // S4: first product of a window loads, later ones add; dump after the L-th.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_re <= '0;
            acc_im <= '0;
            cnt    <= '0;
            len_l  <= '0;
            v4     <= 1'b0;
        end else if (ce) begin
            v4 <= 1'b0;
            if (v3) begin
                if (cnt == '0) begin
                    acc_re <= SW'(re);
                    acc_im <= SW'(im);
                    len_l  <= acc_len;
                end else begin
                    acc_re <= acc_re + SW'(re);
                    acc_im <= acc_im + SW'(im);
                end
                if (last_prod) begin
                    v4  <= 1'b1;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // S5: one-cycle valid pulse aligned with the registered results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
        end else if (ce) begin
            out_valid <= v4;
        end
    end

    sdr_round_sat #(.IW(SW), .OW(OW), .SHIFT(SHIFT)) u_sat_i (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .en    (v4),
        .val   (acc_re),
        .y     (y_i),
        .ovf   (ovf_i)
    );

    sdr_round_sat #(.IW(SW), .OW(OW), .SHIFT(SHIFT)) u_sat_q (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .en    (v4),
        .val   (acc_im),
        .y     (y_q),
        .ovf   (ovf_q)
    );

    assign ovf = ovf_i | ovf_q;

endmodule
